// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-path types and default frame/FIFO sizing
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2,
      ERR     = 2'd3
   } asm_state_t;

   localparam int UART_N_BITS     = 8;
   localparam int UART_FIFO_DEPTH = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO; a push into a full FIFO lands only if a pop frees a slot
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_valid,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_valid   = (r_level != '0);
   assign o_full    = (r_level == LVL_W'(DEPTH));
   assign o_data    = r_mem[r_rd_ptr];
   assign o_level   = r_level;
   assign w_do_pop  = i_pop && o_valid;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_level <= r_level + LVL_W'(w_do_push) - LVL_W'(w_do_pop);
      end
   end

endmodule

// File: rtl/uart_rx_assembler.sv
// rtl/uart_rx_assembler.sv - frames serial bits into bytes and queues good ones; UART_RX_STATS_EN adds err/drop counters
module uart_rx_assembler
   import uart_pkg::*;
#(
   parameter int N_BITS     = UART_N_BITS,
   parameter int FIFO_DEPTH = UART_FIFO_DEPTH
`ifdef UART_RX_STATS_EN
   ,
   parameter int STAT_W     = 16
`endif
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          bit_in,
   input  logic                          bit_valid,
   input  logic                          frame_done,
   input  logic                          frame_ok,
   output logic [N_BITS-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          frame_err,
`ifdef UART_RX_STATS_EN
   output logic                          overflow,
   output logic [STAT_W-1:0]             err_count,
   output logic [STAT_W-1:0]             drop_count
`else
   output logic                          overflow
`endif
);

   localparam int CNT_W = $clog2(N_BITS) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_BITS);

   asm_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [N_BITS-1:0] r_sh;
   logic              r_frame_err;
   logic              r_overflow;

   logic              w_accept;
   logic              w_overrun;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [N_BITS-1:0] w_sh_next;
   logic              w_good;
   logic              w_ferr;
   logic              w_pop;
   logic              w_full;
   logic              w_ovf;

   // The bit arriving alongside frame_done is folded in before the verdict.
   assign w_accept   = bit_valid && ((r_state == IDLE) || (r_state == COLLECT));
   assign w_overrun  = bit_valid && (r_state == FULL);
   assign w_cnt_next = r_cnt + CNT_W'(w_accept);
   assign w_sh_next  = w_accept ? {bit_in, r_sh[N_BITS-1:1]} : r_sh;
   assign w_good     = frame_done && frame_ok && (w_cnt_next == CNT_FULL)
                       && (r_state != ERR) && !w_overrun;
   assign w_ferr     = frame_done && !w_good;
   assign w_pop      = out_valid && out_ready;
   assign w_ovf      = w_good && w_full && !w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_sh        <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_sh        <= w_sh_next;
         r_frame_err <= w_ferr;
         r_overflow  <= w_ovf;
         if (frame_done) begin
            r_state <= IDLE;
            r_cnt   <= '0;
         end else if (w_accept) begin
            r_cnt   <= w_cnt_next;
            r_state <= (w_cnt_next == CNT_FULL) ? FULL : COLLECT;
         end else if (w_overrun) begin
            r_state <= ERR;
         end
      end
   end

   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;

   uart_sync_fifo #(
      .WIDTH (N_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_good),
      .i_data  (w_sh_next),
      .i_pop   (out_ready),
      .o_data  (out_data),
      .o_valid (out_valid),
      .o_full  (w_full),
      .o_level (fifo_level)
   );

`ifdef UART_RX_STATS_EN
   logic [STAT_W-1:0] r_err_count;
   logic [STAT_W-1:0] r_drop_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count  <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_ferr && (r_err_count != '1))  r_err_count  <= r_err_count + STAT_W'(1);
         if (w_ovf && (r_drop_count != '1))  r_drop_count <= r_drop_count + STAT_W'(1);
      end
   end

   assign err_count  = r_err_count;
   assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_uart_rx_assembler.sv
// tb/tb_uart_rx_assembler.sv - directed plus randomized frames checked against a queue-based byte model
module tb_uart_rx_assembler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       frame_done = 1'b0;
   logic       frame_ok = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic [2:0] fifo_level;
   logic       frame_err;
   logic       overflow;
`ifdef UART_RX_STATS_EN
   logic [15:0] err_count;
   logic [15:0] drop_count;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mq[$];
   logic [7:0] cur = 8'h00;
   int         nbits = 0;
   logic       exp_ferr = 1'b0;
   logic       exp_ovf = 1'b0;

   uart_rx_assembler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .frame_done (frame_done),
      .frame_ok   (frame_ok),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .frame_err  (frame_err),
`ifdef UART_RX_STATS_EN
      .overflow   (overflow),
      .err_count  (err_count),
      .drop_count (drop_count)
`else
      .overflow   (overflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_model();
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, mq[0]});
      chk("fifo_level", {29'd0, fifo_level}, mq.size());
      chk("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
      chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
   endtask

   // One clock: apply inputs, advance the byte-level model, then compare after the edge.
   task automatic step(input logic bv, input logic bi, input logic fd, input logic fo, input logic rdy);
      bit pop;
      bit push;
      bit_valid  = bv;
      bit_in     = bi;
      frame_done = fd;
      frame_ok   = fo;
      out_ready  = rdy;
      pop  = (mq.size() != 0) && rdy;
      push = 0;
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
      if (bv) begin
         if (nbits < 8) cur[nbits] = bi;
         nbits++;
      end
      if (fd) begin
         if (nbits == 8 && fo) begin
            if (mq.size() < 4 || pop) push = 1;
            else exp_ovf = 1'b1;
         end else begin
            exp_ferr = 1'b1;
         end
         nbits = 0;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(cur);
      @(posedge clk);
      #1;
      bit_valid  = 1'b0;
      frame_done = 1'b0;
      check_model();
   endtask

   task automatic send_bits(input logic [15:0] d, input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b1, d[i], 1'b0, 1'b0, rdy);
   endtask

   task automatic close_frame(input logic ok, input logic rdy);
      step(1'b0, 1'b0, 1'b1, ok, rdy);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic ok, input logic rdy);
      send_bits({8'd0, d}, 8, rdy);
      close_frame(ok, rdy);
   endtask

   task automatic random_frame();
      int         n;
      int         sel;
      logic [15:0] d;
      logic       ok;
      bit         merge;
      int         bias;
      sel  = $urandom_range(0, 9);
      n    = (sel == 0) ? 0 : (sel == 1) ? 7 : (sel == 2) ? 9 : 8;
      d    = 16'($urandom);
      ok   = ($urandom_range(0, 9) != 0);
      bias = $urandom_range(0, 3);
      merge = (n != 0) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 3) < bias);
         if (merge && i == n - 1) step(1'b1, d[i], 1'b1, ok, $urandom_range(0, 3) < bias);
         else step(1'b1, d[i], 1'b0, 1'b0, $urandom_range(0, 3) < bias);
      end
      if (!merge) close_frame(ok, $urandom_range(0, 3) < bias);
   endtask

   initial begin
      logic [7:0] drain_exp [4];
      drain_exp = '{8'h02, 8'h03, 8'h04, 8'h06};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      rst_n = 1'b1;

      send_byte(8'hA5, 1'b1, 1'b0);
      chk("a5_data", {24'd0, out_data}, 32'hA5);
      chk("a5_level", {29'd0, fifo_level}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      send_byte(8'h3C, 1'b0, 1'b0);
      chk("stop_err_pulse", {31'd0, frame_err}, 32'd1);
      chk("stop_err_level", {29'd0, fifo_level}, 32'd0);

      send_bits(16'h007F, 7, 1'b0);
      close_frame(1'b1, 1'b0);
      chk("len7_err", {31'd0, frame_err}, 32'd1);
      send_bits(16'h01FF, 9, 1'b0);
      close_frame(1'b1, 1'b0);
      chk("len9_err", {31'd0, frame_err}, 32'd1);
      close_frame(1'b1, 1'b0);
      chk("len0_err", {31'd0, frame_err}, 32'd1);
      send_byte(8'h55, 1'b1, 1'b0);
      chk("after_err_55", {24'd0, out_data}, 32'h55);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, 1'b0);
      chk("ovf_pulse", {31'd0, overflow}, 32'd1);
      chk("ovf_level", {29'd0, fifo_level}, 32'd4);
      chk("ovf_head", {24'd0, out_data}, 32'h01);

      send_bits(16'h0006, 8, 1'b0);
      close_frame(1'b1, 1'b1);
      chk("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
      chk("full_pushpop_level", {29'd0, fifo_level}, 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("drain_order", {24'd0, out_data}, {24'd0, drain_exp[k]});
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      chk("drained_level", {29'd0, fifo_level}, 32'd0);

      send_byte(8'h11, 1'b1, 1'b0);
      send_byte(8'h22, 1'b1, 1'b0);
      send_bits(16'h000F, 4, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_level", {29'd0, fifo_level}, 32'd0);
      mq.delete();
      nbits = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_byte(8'h81, 1'b1, 1'b0);
      chk("post_rst_81", {24'd0, out_data}, 32'h81);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int f = 0; f < 80; f++) random_frame();
      repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
